// File: rtl/picoblaze_io_hub.sv
// Addressable I/O hub for a pacoblaze3 core: buffered input channels with
// valid/overrun status, output registers with write pulses, request pulses and a periodic interrupt.
module picoblaze_io_hub #(
    parameter int unsigned clk_freq_in_hz = 25000000,
    parameter int unsigned TICK_HZ        = 1,
    parameter int unsigned NUM_IN         = 4,
    parameter int unsigned NUM_OUT        = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              port_id,
    input  logic [7:0]              out_port,
    input  logic                    write_strobe,
    input  logic                    read_strobe,
    output logic [7:0]              in_port,
    output logic                    interrupt,
    input  logic                    interrupt_ack,
    input  logic [8*NUM_IN-1:0]     in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       req,
    output logic [8*NUM_OUT-1:0]    out_data,
    output logic [NUM_OUT-1:0]      out_wr
);

    localparam int unsigned DIV = clk_freq_in_hz / TICK_HZ;
    localparam int unsigned DW  = $clog2(DIV);

    logic [7:0]             r_hold [NUM_IN];
    logic [NUM_IN-1:0]      r_valid;
    logic [NUM_IN-1:0]      r_ovr;
    logic [7:0]             r_in_port;
    logic [NUM_IN-1:0]      r_req;
    logic [8*NUM_OUT-1:0]   r_out_data;
    logic [NUM_OUT-1:0]     r_out_wr;
    logic                   r_int_en;
    logic                   r_int;
    logic [DW-1:0]          r_div;
    logic [7:0]             r_tick;

    logic [NUM_IN-1:0]      w_rd_hit;
    logic                   w_clr_ovr;
    logic [NUM_IN-1:0]      w_hold_ld;
    logic [NUM_IN-1:0]      w_valid_nxt;
    logic [NUM_IN-1:0]      w_ovr_nxt;
    logic [7:0]             w_hold_sel;
    logic [7:0]             w_rd_data;
    logic [NUM_OUT-1:0]     w_out_wr_nxt;
    logic [NUM_IN-1:0]      w_req_nxt;
    logic                   w_wr_ien;
    logic                   w_wrap;

    // Channel status update: a clearing read of the same channel frees the slot for new data.
    always_comb begin
        w_rd_hit    = {NUM_IN{1'b0}};
        w_hold_ld   = {NUM_IN{1'b0}};
        w_valid_nxt = r_valid;
        w_clr_ovr   = read_strobe && (port_id == 8'h12);
        w_ovr_nxt   = w_clr_ovr ? {NUM_IN{1'b0}} : r_ovr;
        for (int i = 0; i < NUM_IN; i++) begin
            w_rd_hit[i] = read_strobe && (port_id == 8'(i));
            if (in_valid[i] && (!r_valid[i] || w_rd_hit[i])) begin
                w_hold_ld[i]   = 1'b1;
                w_valid_nxt[i] = 1'b1;
            end else if (in_valid[i]) begin
                w_ovr_nxt[i]   = 1'b1;
            end else if (w_rd_hit[i]) begin
                w_valid_nxt[i] = 1'b0;
            end else begin
                w_valid_nxt[i] = r_valid[i];
            end
        end
    end

    // Read mux; addresses below NUM_IN select a hold register.
    always_comb begin
        w_hold_sel = 8'h00;
        for (int i = 0; i < NUM_IN; i++) begin
            w_hold_sel = w_hold_sel | ({8{port_id == 8'(i)}} & r_hold[i]);
        end
        case (port_id)
            8'h10:   w_rd_data = 8'(r_valid);
            8'h11:   w_rd_data = r_tick;
            8'h12:   w_rd_data = 8'(r_ovr);
            default: w_rd_data = w_hold_sel;
        endcase
    end

    // Write decode for output registers, request pulses and interrupt enable.
    always_comb begin
        w_out_wr_nxt = {NUM_OUT{1'b0}};
        for (int j = 0; j < NUM_OUT; j++) begin
            w_out_wr_nxt[j] = write_strobe && (port_id == 8'(32'h80 + j));
        end
        if (write_strobe && (port_id == 8'h40)) begin
            w_req_nxt = out_port[NUM_IN-1:0];
        end else begin
            w_req_nxt = {NUM_IN{1'b0}};
        end
        w_wr_ien = write_strobe && (port_id == 8'h41);
    end

    assign w_wrap = (r_div == DW'(DIV - 1));

    // Input channel storage and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= {NUM_IN{1'b0}};
            r_ovr   <= {NUM_IN{1'b0}};
            for (int i = 0; i < NUM_IN; i++) begin
                r_hold[i] <= 8'h00;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_ovr   <= w_ovr_nxt;
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_hold_ld[i]) begin
                    r_hold[i] <= in_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read data, output registers and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_port  <= 8'h00;
            r_out_data <= {(8*NUM_OUT){1'b0}};
            r_out_wr   <= {NUM_OUT{1'b0}};
            r_req      <= {NUM_IN{1'b0}};
            r_int_en   <= 1'b0;
        end else begin
            r_in_port <= w_rd_data;
            r_out_wr  <= w_out_wr_nxt;
            r_req     <= w_req_nxt;
            for (int j = 0; j < NUM_OUT; j++) begin
                if (w_out_wr_nxt[j]) begin
                    r_out_data[8*j +: 8] <= out_port;
                end
            end
            if (w_wr_ien) begin
                r_int_en <= out_port[0];
            end
        end
    end

    // Tick divider and interrupt; a wrap outranks a same-cycle acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= {DW{1'b0}};
            r_tick <= 8'h00;
            r_int  <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_div  <= {DW{1'b0}};
                r_tick <= r_tick + 8'd1;
            end else begin
                r_div  <= r_div + DW'(1);
            end
            if (w_wrap && r_int_en) begin
                r_int <= 1'b1;
            end else if (interrupt_ack) begin
                r_int <= 1'b0;
            end
        end
    end

    assign in_port   = r_in_port;
    assign interrupt = r_int;
    assign req       = r_req;
    assign out_data  = r_out_data;
    assign out_wr    = r_out_wr;

endmodule

// File: tb/tb_picoblaze_io_hub.sv
// Self-checking bench for picoblaze_io_hub: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_picoblaze_io_hub;

    localparam int CLK_HZ = 100;
    localparam int TICK   = 10;
    localparam int NI     = 4;
    localparam int NO     = 4;
    localparam int DIV    = CLK_HZ / TICK;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [7:0]      port_id = 8'h00;
    logic [7:0]      out_port = 8'h00;
    logic            write_strobe = 1'b0;
    logic            read_strobe = 1'b0;
    logic [7:0]      in_port;
    logic            interrupt;
    logic            interrupt_ack = 1'b0;
    logic [8*NI-1:0] in_data = '0;
    logic [NI-1:0]   in_valid = '0;
    logic [NI-1:0]   req;
    logic [8*NO-1:0] out_data;
    logic [NO-1:0]   out_wr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]    m_hold [NI];
    logic [NI-1:0] m_valid, m_ovr, m_req;
    logic [7:0]    m_out [NO];
    logic [NO-1:0] m_out_wr;
    logic          m_int_en, m_int;
    logic [7:0]    m_in_port;
    int            m_cycles;

    picoblaze_io_hub #(
        .clk_freq_in_hz(CLK_HZ), .TICK_HZ(TICK), .NUM_IN(NI), .NUM_OUT(NO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .in_data(in_data),
        .in_valid(in_valid), .req(req), .out_data(out_data), .out_wr(out_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_tick();
        return 8'((m_cycles / DIV) % 256);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NI; i++) m_hold[i] = 8'h00;
        for (int j = 0; j < NO; j++) m_out[j] = 8'h00;
        m_valid = '0; m_ovr = '0; m_req = '0; m_out_wr = '0;
        m_int_en = 1'b0; m_int = 1'b0; m_in_port = 8'h00; m_cycles = 0;
    endtask

    // Advance one clock, applying the port-map rules to the model from the current inputs.
    task automatic step();
        logic          pre_int_en;
        logic [NI-1:0] set_ovr;
        int            pid;
        pid = int'(port_id);
        if (pid < NI)           m_in_port = m_hold[pid];
        else if (pid == 'h10)   m_in_port = 8'(m_valid);
        else if (pid == 'h11)   m_in_port = m_tick();
        else if (pid == 'h12)   m_in_port = 8'(m_ovr);
        else                    m_in_port = 8'h00;
        set_ovr = '0;
        for (int i = 0; i < NI; i++) begin
            logic hit;
            hit = read_strobe && (pid == i);
            if (in_valid[i]) begin
                if (!m_valid[i] || hit) begin
                    m_hold[i] = in_data[8*i +: 8];
                    m_valid[i] = 1'b1;
                end else begin
                    set_ovr[i] = 1'b1;
                end
            end else if (hit) begin
                m_valid[i] = 1'b0;
            end
        end
        if (read_strobe && pid == 'h12) m_ovr = '0;
        m_ovr = m_ovr | set_ovr;
        pre_int_en = m_int_en;
        m_out_wr = '0;
        m_req = '0;
        if (write_strobe) begin
            if (pid >= 'h80 && pid < 'h80 + NO) begin
                m_out[pid - 'h80] = out_port;
                m_out_wr[pid - 'h80] = 1'b1;
            end else if (pid == 'h40) begin
                m_req = out_port[NI-1:0];
            end else if (pid == 'h41) begin
                m_int_en = out_port[0];
            end
        end
        m_cycles++;
        if ((m_cycles % DIV == 0) && pre_int_en) m_int = 1'b1;
        else if (interrupt_ack)                  m_int = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
        interrupt_ack = 1'b0; in_valid = '0; in_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        m_clear();
        #20;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] id);
        idle_inputs();
        port_id = id; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [7:0] d);
        idle_inputs();
        port_id = id; out_port = d; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        do_write(8'h41, 8'h01);
        idle_inputs();
        while (m_cycles < DIV) step();
        do_write(8'h40, 8'hFF);
        checks++;
        if (req !== 4'hF || interrupt !== 1'b1) begin
            errors++; $display("FAIL reset_pre: req=%h int=%b want req=f int=1", req, interrupt);
        end
        #1 reset_n = 1'b0;
        m_clear();
        #1;
        checks++;
        if (req !== 4'h0 || interrupt !== 1'b0 || in_port !== 8'h00 || out_wr !== 4'h0) begin
            errors++;
            $display("FAIL reset_async: req=%h int=%b in_port=%h out_wr=%h want all 0",
                     req, interrupt, in_port, out_wr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_read(8'h10);
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", in_port); end
        do_read(8'h11);
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL reset_tick: got %h want 00", in_port); end
        do_read(8'h12);
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL reset_ovr: got %h want 00", in_port); end
    endtask

    task automatic test_capture_overrun();
        apply_reset();
        in_valid = 4'b0100; in_data[23:16] = 8'hA5;
        step();
        idle_inputs();
        step();
        in_valid = 4'b0100; in_data[23:16] = 8'h3C;
        step();
        do_read(8'h02);
        checks++;
        if (in_port !== 8'hA5) begin errors++; $display("FAIL cap_hold: got %h want a5", in_port); end
        do_read(8'h12);
        checks++;
        if (in_port !== 8'h04) begin errors++; $display("FAIL cap_ovr: got %h want 04", in_port); end
        do_read(8'h12);
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL cap_ovr_clr: got %h want 00", in_port); end
        do_read(8'h10);
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL cap_valid: got %h want 00", in_port); end
    endtask

    task automatic test_simul_read_capture();
        apply_reset();
        in_valid = 4'b0010; in_data[15:8] = 8'h11;
        step();
        idle_inputs();
        port_id = 8'h01; read_strobe = 1'b1; in_valid = 4'b0010; in_data[15:8] = 8'h22;
        step();
        checks++;
        if (in_port !== 8'h11) begin errors++; $display("FAIL simul_old: got %h want 11", in_port); end
        do_read(8'h10);
        checks++;
        if (in_port !== 8'h02) begin errors++; $display("FAIL simul_valid: got %h want 02", in_port); end
        do_read(8'h01);
        checks++;
        if (in_port !== 8'h22) begin errors++; $display("FAIL simul_new: got %h want 22", in_port); end
        do_read(8'h12);
        checks++;
        if (in_port !== 8'h00) begin errors++; $display("FAIL simul_ovr: got %h want 00", in_port); end
    endtask

    task automatic test_outputs();
        apply_reset();
        do_write(8'h83, 8'h5A);
        checks++;
        if (out_data[31:24] !== 8'h5A || out_wr !== 4'b1000) begin
            errors++; $display("FAIL out_wr3: data=%h wr=%b want 5a 1000", out_data[31:24], out_wr);
        end
        do_write(8'h40, 8'hFF);
        checks++;
        if (req !== 4'b1111 || out_wr !== 4'b0000) begin
            errors++; $display("FAIL out_req: req=%b wr=%b want 1111 0000", req, out_wr);
        end
        idle_inputs();
        step();
        checks++;
        if (req !== 4'b0000) begin errors++; $display("FAIL out_req_pulse: req=%b want 0000", req); end
        do_write(8'h90, 8'h77);
        checks++;
        if (out_data !== 32'h5A00_0000 || out_wr !== 4'b0000) begin
            errors++; $display("FAIL out_unmapped: data=%h wr=%b want 5a000000 0000", out_data, out_wr);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        idle_inputs();
        write_strobe = 1'b1; port_id = 8'h80; out_port = 8'h12;
        step();
        checks++;
        if (out_wr !== 4'b0001) begin errors++; $display("FAIL b2b_first: wr=%b want 0001", out_wr); end
        port_id = 8'h81; out_port = 8'h34;
        step();
        checks++;
        if (out_wr !== 4'b0010 || out_data[15:0] !== 16'h3412) begin
            errors++; $display("FAIL b2b_second: wr=%b data=%h want 0010 3412", out_wr, out_data[15:0]);
        end
        port_id = 8'h40; out_port = 8'h05;
        step();
        port_id = 8'h40; out_port = 8'h0A;
        step();
        checks++;
        if (req !== 4'b1010) begin errors++; $display("FAIL b2b_req: req=%b want 1010", req); end
        idle_inputs();
    endtask

    task automatic test_interrupt();
        apply_reset();
        do_write(8'h41, 8'h01);
        idle_inputs();
        while (m_cycles < DIV - 1) step();
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL int_early: got %b want 0", interrupt); end
        step();
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL int_first: got %b want 1", interrupt); end
        while (m_cycles < 14) step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        checks++;
        if (interrupt !== 1'b0) begin errors++; $display("FAIL int_ack: got %b want 0", interrupt); end
        while (m_cycles < 2 * DIV - 1) step();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL int_ack_wrap: got %b want 1", interrupt); end
        do_read(8'h11);
        checks++;
        if (in_port !== 8'h02) begin errors++; $display("FAIL int_tick: got %h want 02", in_port); end
        do_write(8'h41, 8'h00);
        checks++;
        if (interrupt !== 1'b1) begin errors++; $display("FAIL int_pending: got %b want 1", interrupt); end
    endtask

    task automatic test_masked();
        int seen;
        apply_reset();
        seen = 0;
        for (int k = 0; k < 300 * DIV; k++) begin
            step();
            if (interrupt !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL masked_int: %0d cycles high, want 0", seen); end
        do_read(8'h11);
        checks++;
        if (in_port !== 8'h2C) begin errors++; $display("FAIL masked_tick: got %h want 2c", in_port); end
    endtask

    task automatic test_random();
        logic [7:0] ids [16];
        ids = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12,
                8'h40, 8'h41, 8'h80, 8'h81, 8'h82, 8'h83, 8'h90, 8'hFF};
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            port_id       = ids[$urandom_range(15)];
            out_port      = 8'($urandom);
            write_strobe  = ($urandom_range(3) == 0);
            read_strobe   = ($urandom_range(2) == 0);
            interrupt_ack = ($urandom_range(5) == 0);
            for (int i = 0; i < NI; i++) begin
                in_valid[i] = ($urandom_range(4) == 0);
                in_data[8*i +: 8] = 8'($urandom);
            end
            step();
            checks++;
            if (in_port !== m_in_port) begin
                errors++; $display("FAIL rnd_in_port: cyc %0d got %h want %h", k, in_port, m_in_port);
            end
            checks++;
            if (out_data !== {m_out[3], m_out[2], m_out[1], m_out[0]} || out_wr !== m_out_wr) begin
                errors++;
                $display("FAIL rnd_out: cyc %0d data=%h wr=%b want %h %b", k, out_data, out_wr,
                         {m_out[3], m_out[2], m_out[1], m_out[0]}, m_out_wr);
            end
            checks++;
            if (req !== m_req || interrupt !== m_int) begin
                errors++;
                $display("FAIL rnd_req_int: cyc %0d req=%b int=%b want %b %b", k, req, interrupt, m_req, m_int);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_capture_overrun();
        test_simul_read_capture();
        test_outputs();
        test_back_to_back();
        test_interrupt();
        test_masked();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
